// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcodes, load/store size selects and LSU sequencer states.
package riscv_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] LD_LB      = 3'b000;
   localparam logic [2:0] LD_LH      = 3'b001;
   localparam logic [2:0] LD_LW      = 3'b010;
   localparam logic [2:0] LD_LBU     = 3'b011;
   localparam logic [2:0] LD_LHU     = 3'b100;
   localparam logic [2:0] LD_ILLEGAL = 3'b111;

   localparam logic [1:0] ST_SB      = 2'b00;
   localparam logic [1:0] ST_SH      = 2'b01;
   localparam logic [1:0] ST_SW      = 2'b10;
   localparam logic [1:0] ST_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store enables/replication, load extract/extend,
// and detection of misaligned or unsupported size selects.
module lsu_lane_align
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            is_store,
   input  logic [2:0]      ld_sel,
   input  logic [1:0]      s_sel,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] bus_rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] lane_wdata,
   output logic [XLEN-1:0] load_data,
   output logic            misalign
);

   logic [XLEN-1:0] shifted;

   // Moving the addressed byte/half down to bit 0 lets every load width share one extractor.
   assign shifted = bus_rdata >> {offset, 3'b000};

   always_comb begin
      be         = 4'b1111;
      lane_wdata = wdata;
      misalign   = 1'b0;
      if (is_store) begin
         case (s_sel)
            ST_SB: begin
               be         = 4'b0001 << offset;
               lane_wdata = {(XLEN/8){wdata[7:0]}};
            end
            ST_SH: begin
               be         = offset[1] ? 4'b1100 : 4'b0011;
               lane_wdata = {(XLEN/16){wdata[15:0]}};
               misalign   = offset[0];
            end
            ST_SW: begin
               misalign = |offset;
            end
            default: begin
               be       = 4'b0000;
               misalign = 1'b1;
            end
         endcase
      end else begin
         case (ld_sel)
            LD_LB, LD_LBU: begin
               misalign = 1'b0;
            end
            LD_LH, LD_LHU: begin
               misalign = offset[0];
            end
            LD_LW: begin
               misalign = |offset;
            end
            default: begin
               misalign = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      load_data = '0;
      case (ld_sel)
         LD_LB:   load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         LD_LH:   load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         LD_LW:   load_data = bus_rdata;
         LD_LBU:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         LD_LHU:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: one req/ack bus transaction per memory
// instruction, pipeline stall until completion, error and timeout reporting.
module lsu_sequencer
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = 64
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      ld_sel,
   input  logic [1:0]      s_sel,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] rdata,
   output logic            misalign,
   output logic            fault,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_be,
   input  logic            bus_ack,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   lsu_state_t       state_q;
   lsu_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0]  addr_q;
   logic [XLEN-1:0]  wdata_q;
   logic [XLEN-1:0]  rdata_q;
   logic [2:0]       ld_sel_q;
   logic [1:0]       s_sel_q;
   logic             we_q;
   logic             fault_q;
   logic             misalign_q;

   logic             in_idle;
   logic             in_req;
   logic             in_done;
   logic             op_valid;
   logic             op_both;

   logic             al_store;
   logic [2:0]       al_ld_sel;
   logic [1:0]       al_s_sel;
   logic [1:0]       al_offset;
   logic [3:0]       al_be;
   logic [XLEN-1:0]  al_wdata;
   logic [XLEN-1:0]  al_load;
   logic             al_misalign;

   assign in_idle  = (state_q == IDLE);
   assign in_req   = (state_q == REQ);
   assign in_done  = (state_q == DONE);
   assign op_valid = mem_read | mem_write;
   assign op_both  = mem_read & mem_write;

   // The aligner checks live decode inputs while idle and the latched copy
   // afterwards, so the bus fields cannot move while a request is outstanding.
   assign al_store  = in_idle ? mem_write  : we_q;
   assign al_ld_sel = in_idle ? ld_sel     : ld_sel_q;
   assign al_s_sel  = in_idle ? s_sel      : s_sel_q;
   assign al_offset = in_idle ? addr[1:0]  : addr_q[1:0];

   lsu_lane_align #(
      .XLEN (XLEN)
   ) u_align (
      .is_store   (al_store),
      .ld_sel     (al_ld_sel),
      .s_sel      (al_s_sel),
      .offset     (al_offset),
      .wdata      (wdata_q),
      .bus_rdata  (bus_rdata),
      .be         (al_be),
      .lane_wdata (al_wdata),
      .load_data  (al_load),
      .misalign   (al_misalign)
   );

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      bus_req = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_valid) begin
               stall   = 1'b1;
               state_d = (op_both || al_misalign) ? DONE : REQ;
            end
         end
         REQ: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            if (bus_ack || (cnt_q == CNT_LAST)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Error flags are decided in IDLE or REQ but only become visible during DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         ld_sel_q   <= '0;
         s_sel_q    <= '0;
         we_q       <= 1'b0;
         fault_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               cnt_q      <= '0;
               rdata_q    <= '0;
               addr_q     <= addr;
               wdata_q    <= wdata;
               ld_sel_q   <= ld_sel;
               s_sel_q    <= s_sel;
               we_q       <= mem_write;
               fault_q    <= op_both;
               misalign_q <= op_valid && !op_both && al_misalign;
            end
            REQ: begin
               if (bus_ack) begin
                  rdata_q <= we_q ? '0 : al_load;
               end else if (cnt_q == CNT_LAST) begin
                  fault_q <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q <= cnt_q;
            end
         endcase
      end
   end

   assign rdata     = in_done ? rdata_q : '0;
   assign fault     = in_done & fault_q;
   assign misalign  = in_done & misalign_q;
   assign bus_we    = in_req & we_q;
   assign bus_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign bus_wdata = (in_req && we_q) ? al_wdata : '0;
   assign bus_be    = in_req ? al_be : 4'b0000;

endmodule
